// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared state encoding and a constant clog2 helper for the
//               round-robin register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Minimum bits needed to encode values 0..v-1; returns 1 for v<=2 so that
  // index buses never collapse to zero width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational cyclic priority search: first set bit of req at
//               or after ptr, wrapping around past N-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  found,
  output logic [clog2(N)-1:0]   idx
);

  localparam int IW = clog2(N);

  int j;

  // Walk from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter granting one of N requesters write access
//               to a shared W-bit capture register, with bounded burst length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [clog2(N)-1:0]  owner,
  output logic [W-1:0]         q,
  output logic                 q_valid
);

  localparam int OW = clog2(N);
  localparam int HW = clog2(MAX_HOLD + 1);

  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(MAX_HOLD - 1);

  state_t         state;
  state_t         state_n;
  logic [OW-1:0]  ptr;
  logic [OW-1:0]  ptr_n;
  logic [OW-1:0]  owner_n;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_n;
  logic [N-1:0]   gnt_n;

  logic           accept;
  logic           release_own;
  logic [OW-1:0]  succ;
  logic [OW-1:0]  start;
  logic           pick_found;
  logic [OW-1:0]  pick_idx;
  logic [W-1:0]   owner_data;

  assign accept      = (state == OWN) && req[owner];
  assign release_own = (state == OWN) &&
                       (!req[owner] || (accept && (hold_cnt == LAST_HOLD)));
  assign succ        = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  // On release the search starts just past the outgoing owner so it is tried last.
  assign start       = release_own ? succ : ptr;
  assign owner_data  = wdata[int'(owner) * W +: W];

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .ptr   (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = '0;

    if (release_own) ptr_n = succ;

    if ((state == IDLE) || release_own) begin
      if (pick_found) begin
        state_n = OWN;
        owner_n = pick_idx;
        hold_n  = '0;
      end else begin
        state_n = IDLE;
        owner_n = '0;
        hold_n  = '0;
      end
    end else if (accept) begin
      hold_n = hold_cnt + 1'b1;
    end

    if (state_n == OWN) gnt_n[owner_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      q_valid  <= accept;
      if (accept) q <= owner_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
// ============================================================================
// Module      : tb_rr_reg_arbiter
// Description : Scoreboard bench: a cycle model of the arbitration rules
//               predicts gnt/owner/q/q_valid, a monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_reg_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           q_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic [W-1:0] q;
    logic         q_valid;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit       m_busy  = 0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_hold  = 0;
  bit [7:0] m_q     = 0;
  bit       m_qv    = 0;

  rr_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] lanes(input logic [7:0] d0, input logic [7:0] d1,
                                           input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
    bit acc, rel;
    int s;
    exp_t e;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_q = 0; m_qv = 0;
    end else begin
      acc  = m_busy && rq[m_owner];
      rel  = m_busy && (!rq[m_owner] || (acc && m_hold == MAX_HOLD - 1));
      m_qv = acc;
      if (acc) m_q = wd[m_owner*W +: W];
      if (acc && !rel) m_hold = m_hold + 1;
      if ((!m_busy && rq != 0) || rel) begin
        if (rel) m_ptr = (m_owner + 1) % N;
        s = m_ptr;
        m_busy = 0; m_owner = 0; m_hold = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_busy && rq[(s + k) % N]) begin
            m_busy  = 1;
            m_owner = (s + k) % N;
          end
        end
      end
    end
    e.gnt     = m_busy ? (N'(1) << m_owner) : '0;
    e.owner   = 2'(m_owner);
    e.q       = m_q;
    e.q_valid = m_qv;
    sb.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
    @(negedge clk);
    rst   = r;
    req   = rq;
    wdata = wd;
    model_step(r, rq, wd);
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks += 4;
        if (gnt !== e.gnt) begin
          errors++;
          $display("FAIL gnt cycle %0d: got %b expected %b", cyc, gnt, e.gnt);
        end
        if (owner !== e.owner) begin
          errors++;
          $display("FAIL owner cycle %0d: got %0d expected %0d", cyc, owner, e.owner);
        end
        if (q_valid !== e.q_valid) begin
          errors++;
          $display("FAIL q_valid cycle %0d: got %b expected %b", cyc, q_valid, e.q_valid);
        end
        if (q !== e.q) begin
          errors++;
          $display("FAIL q cycle %0d: got %h expected %h", cyc, q, e.q);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]   rq;
    logic [N*W-1:0] wd;
    logic [N*W-1:0] idx_lanes;
    idx_lanes = lanes(8'h00, 8'h01, 8'h02, 8'h03);

    // Reset with all requesting, then first grant must go to requester 0
    drive(1, 4'b1111, idx_lanes);
    drive(1, 4'b1111, idx_lanes);
    repeat (3) drive(0, 4'b1111, idx_lanes);
    repeat (3) drive(0, 4'b0000, idx_lanes);

    // Short burst from requester 0, then q holds after req drops
    repeat (2) drive(0, 4'b0001, lanes(8'hA5, 8'h11, 8'h22, 8'h33));
    repeat (3) drive(0, 4'b0000, lanes(8'h5A, 8'h11, 8'h22, 8'h33));

    // Full rotation with forced release every MAX_HOLD transfers
    repeat (20) drive(0, 4'b1111, idx_lanes);
    repeat (2) drive(0, 4'b0000, idx_lanes);

    // Sole requester regranted across forced releases without a gap
    repeat (10) drive(0, 4'b0100, lanes(8'h10, 8'h20, 8'h30, 8'h40));
    repeat (2) drive(0, 4'b0000, idx_lanes);

    // Owner drops request while another is waiting
    repeat (3) drive(0, 4'b1010, lanes(8'h01, 8'hB1, 8'h03, 8'hC3));
    repeat (3) drive(0, 4'b1000, lanes(8'h01, 8'hB1, 8'h03, 8'hC3));
    repeat (2) drive(0, 4'b0000, idx_lanes);

    // Reset mid-burst, then restart from requester 0
    repeat (3) drive(0, 4'b0010, lanes(8'h01, 8'h77, 8'h03, 8'h04));
    drive(1, 4'b1111, idx_lanes);
    repeat (4) drive(0, 4'b1111, idx_lanes);

    // Randomised traffic with sticky requests and rare resets
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      wd = {$urandom(), $urandom()};
      drive($urandom_range(0, 99) == 0, rq, wd[N*W-1:0]);
    end

    drive(0, 4'b0000, idx_lanes);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
